// File: rtl/osc_frame_scheduler.sv
// Oscilloscope capture scheduler: arms on run/single, captures one frame of samples
// on a rising-edge trigger or auto-timeout, and swaps RAM banks at the next vblank.
module osc_frame_scheduler #(
    parameter int N_SAMPLES    = 640,
    parameter int ADDR_WIDTH   = 10,
    parameter int SAMPLE_WIDTH = 8,
    parameter int AUTO_FRAMES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    single,
    input  logic [SAMPLE_WIDTH-1:0] trig_level,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    vsync,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic                    wr_bank,
    output logic                    rd_bank,
    output logic                    frame_ready,
    output logic                    armed,
    output logic                    auto_trig
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int                    FCW       = $clog2(AUTO_FRAMES + 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_SAMPLES - 1);
    localparam logic [FCW-1:0]        AUTO_LAST = FCW'((AUTO_FRAMES == 0) ? 0 : AUTO_FRAMES - 1);

    logic [1:0]              state;
    logic                    vsync_d;
    logic [SAMPLE_WIDTH-1:0] prev;
    logic                    prev_valid;
    logic [FCW-1:0]          frame_cnt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    auto_flag;
    logic                    single_pend;

    logic vblank;
    logic trig_hit;
    logic auto_hit;

    assign vblank   = vsync_d & ~vsync;
    assign trig_hit = sample_valid & prev_valid & (prev < trig_level) & (sample >= trig_level);
    assign auto_hit = (AUTO_FRAMES != 0) & vblank & (frame_cnt == AUTO_LAST);
    assign armed    = (state == S_ARMED);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            vsync_d     <= 1'b1;
            prev        <= '0;
            prev_valid  <= 1'b0;
            frame_cnt   <= '0;
            cap_addr    <= '0;
            auto_flag   <= 1'b0;
            single_pend <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_bank     <= 1'b1;
            rd_bank     <= 1'b0;
            frame_ready <= 1'b0;
            auto_trig   <= 1'b0;
        end else begin
            vsync_d     <= vsync;
            wr_en       <= 1'b0;
            frame_ready <= 1'b0;
            if (single) single_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    prev_valid <= 1'b0;
                    frame_cnt  <= '0;
                    if (run || single || single_pend) state <= S_ARMED;
                end

                S_ARMED: begin
                    if (!run && !single && !single_pend) begin
                        state <= S_IDLE;
                    end else if (trig_hit) begin
                        // Trigger wins over a coincident auto-timeout.
                        wr_en       <= 1'b1;
                        wr_addr     <= '0;
                        wr_data     <= sample;
                        cap_addr    <= ADDR_WIDTH'(1);
                        auto_flag   <= 1'b0;
                        single_pend <= 1'b0;
                        state       <= (N_SAMPLES == 1) ? S_DONE : S_CAPTURE;
                    end else if (auto_hit) begin
                        cap_addr    <= '0;
                        auto_flag   <= 1'b1;
                        single_pend <= 1'b0;
                        state       <= S_CAPTURE;
                    end else begin
                        if (sample_valid) begin
                            prev       <= sample;
                            prev_valid <= 1'b1;
                        end
                        if (vblank) frame_cnt <= frame_cnt + 1'b1;
                    end
                end

                S_CAPTURE: begin
                    if (sample_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cap_addr;
                        wr_data <= sample;
                        if (cap_addr == LAST_ADDR) state <= S_DONE;
                        else cap_addr <= cap_addr + 1'b1;
                    end
                end

                default: begin
                    // Only a vblank seen while already in DONE swaps banks.
                    if (vblank) begin
                        rd_bank     <= ~rd_bank;
                        wr_bank     <= rd_bank;
                        frame_ready <= 1'b1;
                        auto_trig   <= auto_flag;
                        prev_valid  <= 1'b0;
                        frame_cnt   <= '0;
                        state       <= run ? S_ARMED : S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_frame_scheduler.sv
// Directed bench for osc_frame_scheduler with N_SAMPLES=8, AUTO_FRAMES=2.
module tb_osc_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       single;
    logic [7:0] trig_level;
    logic       sample_valid;
    logic [7:0] sample;
    logic       vsync;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_bank;
    logic       rd_bank;
    logic       frame_ready;
    logic       armed;
    logic       auto_trig;

    int checks   = 0;
    int failures = 0;

    osc_frame_scheduler #(
        .N_SAMPLES   (8),
        .ADDR_WIDTH  (3),
        .SAMPLE_WIDTH(8),
        .AUTO_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .single      (single),
        .trig_level  (trig_level),
        .sample_valid(sample_valid),
        .sample      (sample),
        .vsync       (vsync),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .frame_ready (frame_ready),
        .armed       (armed),
        .auto_trig   (auto_trig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, advance one clock, then settle 1ns past the edge.
    task automatic cyc(input logic v, input logic [7:0] s, input logic vs);
        sample_valid = v;
        sample       = s;
        vsync        = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [2:0] a, input logic [7:0] d);
        chk({tag, "_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, "_data"}, 32'(wr_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; single = 1'b0; trig_level = 8'h80;
        sample_valid = 1'b0; sample = 8'h00; vsync = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'd1);
        chk("rst_rd_bank", 32'(rd_bank), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_auto_trig", 32'(auto_trig), 32'd0);
        rst = 1'b0;

        // Rising-edge trigger capture with run=1.
        run = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        chk("arm_armed", 32'(armed), 32'd1);
        cyc(1'b1, 8'h10, 1'b1);
        chk("t1_first_no_wr", 32'(wr_en), 32'd0);
        cyc(1'b1, 8'h70, 1'b1);
        chk("t1_below_no_wr", 32'(wr_en), 32'd0);
        cyc(1'b1, 8'h90, 1'b1);
        chk_write("t1_w0", 3'd0, 8'h90);
        chk("t1_armed_off", 32'(armed), 32'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 8'(8'h90 + i), 1'b1);
            chk_write($sformatf("t1_w%0d", i), 3'(i), 8'(8'h90 + i));
        end
        cyc(1'b1, 8'hEE, 1'b1);
        chk("t1_done_no_wr", 32'(wr_en), 32'd0);
        chk("t1_done_rd_bank", 32'(rd_bank), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t1_swap_fr", 32'(frame_ready), 32'd1);
        chk("t1_swap_rd", 32'(rd_bank), 32'd1);
        chk("t1_swap_wr", 32'(wr_bank), 32'd0);
        chk("t1_swap_auto", 32'(auto_trig), 32'd0);
        chk("t1_rearmed", 32'(armed), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t1_fr_pulse", 32'(frame_ready), 32'd0);

        // Auto-capture after two vsync falls with no trigger.
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'h20, 1'b1);
        chk("t2_no_trig", 32'(wr_en), 32'd0);
        cyc(1'b1, 8'h20, 1'b0);
        chk("t2_vs1_armed", 32'(armed), 32'd1);
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b0, 8'h20, 1'b0);
        chk("t2_vs2_capture", 32'(armed), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'h20, 1'b1);
            chk_write($sformatf("t2_w%0d", i), 3'(i), 8'h20);
        end
        run = 1'b0;
        cyc(1'b1, 8'h20, 1'b1);
        chk("t2_done_no_wr", 32'(wr_en), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t2_swap_fr", 32'(frame_ready), 32'd1);
        chk("t2_swap_rd", 32'(rd_bank), 32'd0);
        chk("t2_swap_wr", 32'(wr_bank), 32'd1);
        chk("t2_swap_auto", 32'(auto_trig), 32'd1);
        chk("t2_idle", 32'(armed), 32'd0);

        // Single-shot with run=0; last write coincides with a vsync fall.
        cyc(1'b0, 8'h00, 1'b1);
        single = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        single = 1'b0;
        chk("t3_armed", 32'(armed), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t3_pending_hold", 32'(armed), 32'd1);
        cyc(1'b1, 8'h50, 1'b1);
        cyc(1'b1, 8'hA0, 1'b1);
        chk_write("t3_w0", 3'd0, 8'hA0);
        for (int i = 1; i < 7; i++) begin
            cyc(1'b1, 8'(8'hA0 + i), 1'b1);
            chk_write($sformatf("t3_w%0d", i), 3'(i), 8'(8'hA0 + i));
        end
        cyc(1'b1, 8'hA7, 1'b0);
        chk_write("t3_w7", 3'd7, 8'hA7);
        chk("t3_coinc_no_fr", 32'(frame_ready), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t3_low_no_fr", 32'(frame_ready), 32'd0);
        chk("t3_low_rd", 32'(rd_bank), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t3_high_no_fr", 32'(frame_ready), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t3_swap_fr", 32'(frame_ready), 32'd1);
        chk("t3_swap_rd", 32'(rd_bank), 32'd1);
        chk("t3_swap_auto", 32'(auto_trig), 32'd0);
        chk("t3_idle", 32'(armed), 32'd0);
        cyc(1'b1, 8'h10, 1'b1);
        chk("t3_idle_no_wr_a", 32'(wr_en), 32'd0);
        cyc(1'b1, 8'h90, 1'b1);
        chk("t3_idle_no_wr_b", 32'(wr_en), 32'd0);
        chk("t3_still_idle", 32'(armed), 32'd0);

        // Asynchronous reset in the middle of a capture.
        run = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h00, 1'b1);
        cyc(1'b1, 8'h85, 1'b1);
        chk_write("t4_w0", 3'd0, 8'h85);
        cyc(1'b1, 8'h86, 1'b1);
        cyc(1'b1, 8'h87, 1'b1);
        chk_write("t4_w2", 3'd2, 8'h87);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_wr_en", 32'(wr_en), 32'd0);
        chk("t4_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("t4_rst_wr_data", 32'(wr_data), 32'd0);
        chk("t4_rst_rd", 32'(rd_bank), 32'd0);
        chk("t4_rst_wr_bank", 32'(wr_bank), 32'd1);
        chk("t4_rst_armed", 32'(armed), 32'd0);
        chk("t4_rst_fr", 32'(frame_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b0;
        cyc(1'b1, 8'h88, 1'b1);
        chk("t4_post_no_wr_a", 32'(wr_en), 32'd0);
        cyc(1'b1, 8'h89, 1'b0);
        chk("t4_post_no_wr_b", 32'(wr_en), 32'd0);
        chk("t4_post_rd", 32'(rd_bank), 32'd0);
        chk("t4_post_fr", 32'(frame_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osc_frame_scheduler.md
OSC_FRAME_SCHEDULER -- requirements
Module: osc_frame_scheduler

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 640, meaning samples per captured frame (one per display column).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning sample-RAM address width; N_SAMPLES <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 8, meaning unsigned sample width.
REQ-004 SHALL have parameter AUTO_FRAMES, default 4, meaning vsync frames without a trigger before auto-capture; 0 disables auto-capture.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port run, input, 1, continuous-capture enable (level).
REQ-008 SHALL have port single, input, 1, one-shot arm request (1-cycle pulse).
REQ-009 SHALL have port trig_level, input, SAMPLE_WIDTH, rising-edge trigger threshold.
REQ-010 SHALL have port sample_valid, input, 1, sample strobe.
REQ-011 SHALL have port sample, input, SAMPLE_WIDTH, ADC sample.
REQ-012 SHALL have port vsync, input, 1, active-low vertical sync from the VGA timing generator.
REQ-013 SHALL have ports wr_en (1), wr_addr (ADDR_WIDTH), wr_data (SAMPLE_WIDTH), outputs, registered sample-RAM write port.
REQ-014 SHALL have ports wr_bank and rd_bank, outputs, 1 each, RAM bank being written / bank displayed; always complementary.
REQ-015 SHALL have port frame_ready, output, 1, 1-cycle pulse at bank swap.
REQ-016 SHALL have ports armed (1) and auto_trig (1), outputs: state is ARMED; last swapped frame was auto-triggered.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-018 SHALL detect vblank start as vsync_d=1 and vsync=0 (falling edge), vsync_d registered.
REQ-019 IDLE: SHALL go ARMED when run=1 or single=1; clear prev_valid and frame counter.
REQ-020 ARMED: first sample_valid after entry SHALL only load prev; no trigger possible on it.
REQ-021 ARMED: trigger SHALL fire on sample_valid with prev_valid, prev < trig_level, sample >= trig_level (unsigned); triggering sample written to address 0, state -> CAPTURE.
REQ-022 ARMED: each vblank start SHALL increment frame counter; on reaching AUTO_FRAMES (non-zero) -> CAPTURE with auto flag set; next valid sample written to address 0.
REQ-023 ARMED: run=0 with no pending single SHALL return to IDLE; single latched as pending until the next capture starts.
REQ-024 CAPTURE: each sample_valid SHALL write sample to next address; after address N_SAMPLES-1 is written -> DONE; run deassertion SHALL NOT abort capture.
REQ-025 Write port SHALL have 1-cycle latency: wr_en/wr_addr/wr_data registered on the cycle after sample_valid; wr_en=0 otherwise; wr_addr never exceeds N_SAMPLES-1.
REQ-026 DONE: on vblank start SHALL toggle rd_bank (wr_bank follows), pulse frame_ready, update auto_trig; then -> ARMED if run=1, else IDLE.
REQ-027 Vblank start in the same cycle as the CAPTURE->DONE transition SHALL be ignored; swap waits for the next vblank.
REQ-028 Trigger and auto-timeout in the same cycle SHALL resolve as trigger (auto_trig=0).
REQ-029 Samples arriving in IDLE or DONE SHALL be discarded (no write).

Reset
REQ-030 On rst: state IDLE, wr_en 0, wr_addr 0, wr_data 0, wr_bank 1, rd_bank 0, frame_ready 0, armed 0, auto_trig 0, vsync_d 1, prev_valid 0, counters 0, pending single 0.
REQ-031 Reset mid-CAPTURE SHALL abandon the frame immediately; no swap, no further writes.

Verification (N_SAMPLES=8, SAMPLE_WIDTH=8, AUTO_FRAMES=2)
REQ-032 run=1, trig_level=0x80, samples 0x10,0x70,0x90,then 0x91..0x97 -> writes addr0=0x90 .. addr7=0x97, then DONE; next vsync fall -> rd_bank=1, frame_ready 1 cycle, auto_trig=0.
REQ-033 run=1, constant sample 0x20, trig_level 0x80, 2 vsync falls -> CAPTURE; 8 writes of 0x20; next vsync fall swap with auto_trig=1.
REQ-034 single pulse, run=0, valid trigger -> one frame captured and swapped, then IDLE; further samples produce no writes.
REQ-035 Last write and vsync fall same cycle -> no swap; swap and frame_ready on the following vsync fall.
REQ-036 rst asserted after 3 writes -> all outputs to reset values asynchronously; wr_en stays 0; rd_bank stays 0.
